// File: rtl/e203_ifu_pkg.sv
// Shared definitions for the IFU flush/response tracking logic.
package e203_ifu_pkg;

    localparam int E203_PC_SIZE = 32;

    // Flush sequencing: IDLE -> (DRAIN ->) REDIR -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } flush_state_e;

endpackage

// File: rtl/e203_ifu_flush_cnt.sv
// Small saturating up/down counter with synchronous load, used for both the
// outstanding-fetch count and the stale-response drop count.
module e203_ifu_flush_cnt #(
    parameter int W   = 2,
    parameter int MAX = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            if (count != MAX_V) count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) count <= count - 1'b1;
        end
    end

    // A request while already full means the fetch bus broke its outstanding limit
    always_ff @(posedge clk) begin
        if (rst_n && !load) assert (!(inc && !dec && count == MAX_V));
    end

endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// Accepts commit-side flushes, discards responses to fetches issued before the
// flush, then issues a single redirect fetch to the flush target.
module e203_ifu_flush_rsp
    import e203_ifu_pkg::*;
#(
    parameter int E203_PC_SIZE = e203_ifu_pkg::E203_PC_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_flush_req,
    input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op2,
    output logic                    pipe_flush_ack,
    input  logic                    ifu_req_hsked,
    input  logic                    ifu_rsp_hsked,
    output logic                    ifu_rsp_drop,
    output logic                    fetch_stall,
    output logic                    redir_req_valid,
    output logic [E203_PC_SIZE-1:0] redir_req_pc,
    input  logic                    redir_req_ready
);

    flush_state_e state, state_nxt;

    logic [1:0]              out_cnt;
    logic [1:0]              drop_cnt;
    logic [1:0]              drop_ld_val;
    logic                    drop_ld;
    logic                    drop_dec;
    logic                    tgt_ld;
    logic [E203_PC_SIZE-1:0] tgt_sum;
    logic [E203_PC_SIZE-1:0] tgt_pc;

    e203_ifu_flush_cnt #(.W(2), .MAX(2)) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val (2'd0),
        .inc      (ifu_req_hsked),
        .dec      (ifu_rsp_hsked),
        .count    (out_cnt)
    );

    e203_ifu_flush_cnt #(.W(2), .MAX(2)) u_drop_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (drop_ld),
        .load_val (drop_ld_val),
        .inc      (1'b0),
        .dec      (drop_dec),
        .count    (drop_cnt)
    );

    // A response arriving in the flush cycle belongs to the old stream but is
    // already consumed, so it is not counted as stale.
    assign drop_ld_val = (ifu_rsp_hsked && out_cnt != 2'd0) ? out_cnt - 2'd1 : out_cnt;
    assign tgt_sum     = pipe_flush_add_op1 + pipe_flush_add_op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tgt_pc <= '0;
        end else begin
            state <= state_nxt;
            if (tgt_ld) tgt_pc <= {tgt_sum[E203_PC_SIZE-1:1], 1'b0};
        end
    end

    always_comb begin
        state_nxt       = state;
        pipe_flush_ack  = 1'b0;
        tgt_ld          = 1'b0;
        drop_ld         = 1'b0;
        drop_dec        = 1'b0;
        redir_req_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                pipe_flush_ack = pipe_flush_req;
                if (pipe_flush_req) begin
                    tgt_ld    = 1'b1;
                    drop_ld   = 1'b1;
                    state_nxt = (drop_ld_val == 2'd0) ? ST_REDIR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Newer flush only retargets; the stale count is unaffected
                pipe_flush_ack = pipe_flush_req;
                tgt_ld         = pipe_flush_req;
                drop_dec       = ifu_rsp_hsked;
                if ((drop_cnt == 2'd1 && ifu_rsp_hsked) || drop_cnt == 2'd0)
                    state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                redir_req_valid = 1'b1;
                if (redir_req_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ifu_rsp_drop = (drop_cnt != 2'd0);
    assign fetch_stall  = (state != ST_IDLE);
    assign redir_req_pc = tgt_pc;

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Directed plus randomized checks of the flush/response tracker against a
// count-based reference model.
module tb_e203_ifu_flush_rsp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_flush_req = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        pipe_flush_ack;
    logic        ifu_req_hsked = 1'b0;
    logic        ifu_rsp_hsked = 1'b0;
    logic        ifu_rsp_drop;
    logic        fetch_stall;
    logic        redir_req_valid;
    logic [31:0] redir_req_pc;
    logic        redir_req_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetches in flight, responses still to discard,
    // whether a redirect is being offered, and the latest flush target.
    int          m_out   = 0;
    int          m_stale = 0;
    bit          m_redir = 1'b0;
    logic [31:0] m_tgt   = '0;

    e203_ifu_flush_rsp #(.E203_PC_SIZE(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_add_op1 (op1),
        .pipe_flush_add_op2 (op2),
        .pipe_flush_ack     (pipe_flush_ack),
        .ifu_req_hsked      (ifu_req_hsked),
        .ifu_rsp_hsked      (ifu_rsp_hsked),
        .ifu_rsp_drop       (ifu_rsp_drop),
        .fetch_stall        (fetch_stall),
        .redir_req_valid    (redir_req_valid),
        .redir_req_pc       (redir_req_pc),
        .redir_req_ready    (redir_req_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Drive one cycle at the falling edge, check outputs, then advance the model.
    task automatic step(input logic req, input logic [31:0] a, input logic [31:0] b,
                        input logic reqh, input logic rsph, input logic rdy);
        bit accepted;
        @(negedge clk);
        pipe_flush_req  = req;
        op1             = a;
        op2             = b;
        ifu_req_hsked   = reqh;
        ifu_rsp_hsked   = rsph;
        redir_req_ready = rdy;
        #1;
        chk("ack",   pipe_flush_ack,  32'(req && !m_redir));
        chk("valid", redir_req_valid, 32'(m_redir));
        chk("pc",    redir_req_pc,    m_tgt);
        chk("drop",  ifu_rsp_drop,    32'(m_stale != 0));
        chk("stall", fetch_stall,     32'(m_stale != 0 || m_redir));

        accepted = req && !m_redir;
        if (m_redir) begin
            if (rdy) m_redir = 1'b0;
        end else if (m_stale == 0) begin
            if (accepted) begin
                m_tgt   = (a + b) & ~32'd1;
                m_stale = m_out - int'(rsph);
                if (m_stale == 0) m_redir = 1'b1;
            end
        end else begin
            if (accepted) m_tgt = (a + b) & ~32'd1;
            if (rsph) begin
                m_stale--;
                if (m_stale == 0) m_redir = 1'b1;
            end
        end
        m_out = m_out + int'(reqh) - int'(rsph);
    endtask

    initial begin
        logic        r_req, r_reqh, r_rsph, r_rdy;
        logic [31:0] r_a, r_b;

        // Reset values
        #12;
        chk("rst_ack",   pipe_flush_ack,  32'd0);
        chk("rst_drop",  ifu_rsp_drop,    32'd0);
        chk("rst_stall", fetch_stall,     32'd0);
        chk("rst_valid", redir_req_valid, 32'd0);
        chk("rst_pc",    redir_req_pc,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle flush with nothing outstanding: redirect next cycle
        step(1, 32'h8000_0000, 32'h0000_0011, 0, 0, 0);
        chk("t033_ack", pipe_flush_ack, 32'd1);
        step(0, 0, 0, 1, 0, 1);
        chk("t033_valid", redir_req_valid, 32'd1);
        chk("t033_pc",    redir_req_pc,    32'h8000_0010);
        step(0, 0, 0, 0, 1, 0);

        // Two outstanding fetches drained before the redirect
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h1000, 32'h20, 0, 0, 0);
        chk("t034_ack", pipe_flush_ack, 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("t034_stall0", fetch_stall, 32'd1);
        step(0, 0, 0, 0, 1, 0);
        chk("t034_drop1", ifu_rsp_drop, 32'd1);
        step(0, 0, 0, 0, 1, 0);
        chk("t034_drop2",  ifu_rsp_drop,    32'd1);
        chk("t034_nvalid", redir_req_valid, 32'd0);
        step(0, 0, 0, 1, 0, 1);
        chk("t034_valid", redir_req_valid, 32'd1);
        chk("t034_pc",    redir_req_pc,    32'h1020);
        chk("t034_stall", fetch_stall,     32'd1);
        step(0, 0, 0, 0, 1, 0);
        chk("t034_idle", fetch_stall, 32'd0);

        // Flush during drain retargets but keeps the stale count
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h200, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 32'h100, 32'h4, 0, 0, 0);
        chk("t035_ack", pipe_flush_ack, 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("t035_pc",   redir_req_pc, 32'h104);
        chk("t035_drop", ifu_rsp_drop, 32'd1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("t035_valid", redir_req_valid, 32'd1);
        chk("t035_rpc",   redir_req_pc,    32'h104);
        step(0, 0, 0, 0, 1, 0);

        // Back-pressured redirect with a held flush
        step(1, 32'h300, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h400, 32'h0, 0, 0, 0);
            chk("t036_nack",  pipe_flush_ack,  32'd0);
            chk("t036_valid", redir_req_valid, 32'd1);
            chk("t036_pc",    redir_req_pc,    32'h300);
        end
        step(1, 32'h400, 32'h0, 1, 0, 1);
        chk("t036_hsk_nack", pipe_flush_ack, 32'd0);
        step(1, 32'h400, 32'h0, 0, 1, 0);
        chk("t036_ack", pipe_flush_ack, 32'd1);
        step(0, 0, 0, 1, 0, 1);
        chk("t036_pc2", redir_req_pc, 32'h400);
        step(0, 0, 0, 0, 1, 0);

        // Target wrap; same-cycle response skips the drain
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'hFFFF_FFFE, 32'h4, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("t037_valid", redir_req_valid, 32'd1);
        chk("t037_pc",    redir_req_pc,    32'h2);
        step(0, 0, 0, 0, 1, 0);

        // Constrained-random traffic
        for (int i = 0; i < 400; i++) begin
            r_a   = $urandom;
            r_b   = $urandom;
            r_req = ($urandom_range(0, 3) == 0);
            r_rdy = $urandom_range(0, 1);
            if (m_redir) begin
                r_reqh = r_rdy;
                r_rsph = 1'b0;
            end else if (m_stale != 0) begin
                r_reqh = 1'b0;
                r_rsph = (m_out > 0) && $urandom_range(0, 1);
            end else begin
                r_rsph = (m_out > 0) && $urandom_range(0, 1);
                r_reqh = !r_req && (m_out < 2 || r_rsph) && $urandom_range(0, 1);
            end
            step(r_req, r_a, r_b, r_reqh, r_rsph, r_rdy);
        end
        // Let any pending redirect complete and responses return
        for (int i = 0; i < 8; i++) begin
            if (m_redir)          step(0, 0, 0, 1, 0, 1);
            else if (m_out > 0)   step(0, 0, 0, 0, 1, 0);
            else                  step(0, 0, 0, 0, 0, 0);
        end

        // Asynchronous reset during drain
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h500, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t038_pre_stall", fetch_stall, 32'd1);
        @(negedge clk);
        pipe_flush_req = 1'b0;
        ifu_req_hsked  = 1'b0;
        ifu_rsp_hsked  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t038_stall", fetch_stall,     32'd0);
        chk("t038_drop",  ifu_rsp_drop,    32'd0);
        chk("t038_valid", redir_req_valid, 32'd0);
        chk("t038_pc",    redir_req_pc,    32'd0);
        chk("t038_ack",   pipe_flush_ack,  32'd0);
        m_out   = 0;
        m_stale = 0;
        m_redir = 1'b0;
        m_tgt   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("t038_idle", fetch_stall, 32'd0);
        step(1, 32'h600, 32'h8, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("t038_redir_pc", redir_req_pc, 32'h608);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
